// File: rtl/sail_stdout_pkg.sv
// Shared types and constants for the Sail stdout drain block.
package sail_stdout_pkg;

    typedef enum logic {DRAIN_IDLE, DRAIN_COPY} drain_state_t;

    localparam byte SAIL_NEWLINE = 8'h0A;
    localparam int  SAIL_STDOUT_FIFO_DEPTH = 16;

endpackage

// File: rtl/sail_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; output is read from registered storage (no bypass).
module sail_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [DEPTH-1:0][7:0]   mem;
    logic                    do_push;
    logic                    do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sail_stdout_drain.sv
// Streams the newly appended suffix of the cumulative Sail stdout string, one byte per cycle.
module sail_stdout_drain
    import sail_stdout_pkg::*;
#(
    parameter int DEPTH = SAIL_STDOUT_FIFO_DEPTH,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_commit,
    input  string            in_sail_stdout,
    output logic             commit_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_eol,
    output logic [LEN_W-1:0] drained_len,
    output logic             trunc_err
);

    localparam logic [63:0]      LEN_MAX64 = (LEN_W >= 64) ? '1 : ((64'd1 << LEN_W) - 64'd1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(LEN_MAX64);

    drain_state_t     state;
    drain_state_t     state_nxt;
    string            snap;
    logic [LEN_W-1:0] snap_len;
    logic [LEN_W-1:0] cursor;
    logic [63:0]      raw_len;
    logic [LEN_W-1:0] commit_len;
    logic             push;
    logic [7:0]       copy_byte;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

    // Strings longer than the counter range are clipped to the saturation point.
    assign raw_len    = 64'(unsigned'(in_sail_stdout.len()));
    assign commit_len = (raw_len > LEN_MAX64) ? LEN_MAX : LEN_W'(raw_len);
    assign copy_byte  = snap[int'(cursor)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DRAIN_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                if (in_commit && (commit_len > drained_len)) state_nxt = DRAIN_COPY;
            end
            DRAIN_COPY: begin
                if (!fifo_full) begin
                    push = 1'b1;
                    if (cursor + LEN_W'(1) == snap_len) state_nxt = DRAIN_IDLE;
                end
            end
            default: state_nxt = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap        <= "";
            snap_len    <= '0;
            cursor      <= '0;
            drained_len <= '0;
            trunc_err   <= 1'b0;
        end else begin
            if (state == DRAIN_IDLE && in_commit) begin
                snap     <= in_sail_stdout;
                snap_len <= commit_len;
                cursor   <= drained_len;
                // A shorter string means upstream restarted; follow it rather than stall.
                if (commit_len < drained_len) begin
                    trunc_err   <= 1'b1;
                    drained_len <= commit_len;
                end
            end
            if (push) begin
                cursor <= cursor + LEN_W'(1);
                if (drained_len != LEN_MAX) drained_len <= drained_len + LEN_W'(1);
            end
        end
    end

    sail_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (copy_byte),
        .full  (fifo_full),
        .pop   (out_valid && out_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign commit_ready = (state == DRAIN_IDLE);
    assign out_valid    = !fifo_empty;
    assign out_byte     = out_valid ? fifo_dout : 8'h00;
    assign out_eol      = out_valid && (out_byte == SAIL_NEWLINE);

endmodule

// File: tb/tb_sail_stdout_drain.sv
// Randomised self-checking bench: a byte-queue model of the cumulative-suffix rule.
module tb_sail_stdout_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_commit = 1'b0;
    string       stdout_str = "";
    logic        commit_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_eol;
    logic [31:0] drained_len;
    logic        trunc_err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          ready_mode = 0;
    logic [7:0]  exp_q[$];
    int          m_drained = 0;
    logic        m_trunc = 1'b0;

    sail_stdout_drain #(.DEPTH(16), .LEN_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_commit      (in_commit),
        .in_sail_stdout (stdout_str),
        .commit_ready   (commit_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_byte       (out_byte),
        .out_eol        (out_eol),
        .drained_len    (drained_len),
        .trunc_err      (trunc_err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every transfer must match the head of the expected byte stream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_byte_q", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [7:0] b;
                b = exp_q.pop_front();
                chk("byte", out_byte, b);
                chk("eol", out_eol, b == 8'h0A);
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        m_drained = 0;
        m_trunc   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_commit(input string s);
        int n;
        for (int i = 0; i < 2000 && !commit_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("commit_wait", commit_ready, 1'b1);
        n = s.len();
        if (n > m_drained) begin
            for (int i = m_drained; i < n; i++) begin
                logic [7:0] c;
                c = s[i];
                exp_q.push_back(c);
            end
        end else if (n < m_drained) begin
            m_trunc = 1'b1;
        end
        m_drained  = n;
        stdout_str = s;
        in_commit  = 1'b1;
        @(posedge clk);
        #1 in_commit = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000 && !(commit_ready && !out_valid && exp_q.size() == 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_idle"}, commit_ready && !out_valid, 1'b1);
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_len"}, drained_len, 64'(m_drained));
        chk({tag, "_trunc"}, trunc_err, m_trunc);
    endtask

    function automatic string rand_chars(input int n);
        string r;
        string c;
        r = "";
        for (int i = 0; i < n; i++) begin
            c = " ";
            c[0] = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(1, 255));
            r = {r, c};
        end
        return r;
    endfunction

    initial begin
        string s;
        #1;
        chk("rst_ready", commit_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_byte", out_byte, 8'h00);
        chk("rst_len", drained_len, 32'd0);
        chk("rst_trunc", trunc_err, 1'b0);
        do_reset();

        // Latency and basic stream
        ready_mode = 1;
        do_commit("hi\n");
        chk("lat_t1", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_t2", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("stream_t3", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("stream_t4", out_valid, 1'b1);
        wait_idle("hi");

        // Incremental suffix only
        do_reset();
        do_commit("ab");
        wait_idle("ab");
        do_commit("abcd");
        wait_idle("abcd");

        // Backpressure: FIFO fills, copy stalls
        do_reset();
        ready_mode = 0;
        #10;
        do_commit("ABCDEFGHIJKLMNOPQRST");
        repeat (30) @(posedge clk);
        #1;
        chk("stall_ready", commit_ready, 1'b0);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_len", drained_len, 32'd16);
        chk("stall_byte", out_byte, 8'h41);
        ready_mode = 1;
        wait_idle("stall");

        // Truncation resync
        do_reset();
        do_commit("abcd");
        wait_idle("tr_a");
        do_commit("xy");
        wait_idle("tr_b");
        do_commit("xyz");
        wait_idle("tr_c");

        // Identical recommit
        do_reset();
        do_commit("qq");
        wait_idle("same_a");
        do_commit("qq");
        chk("same_ready", commit_ready, 1'b1);
        wait_idle("same_b");

        // Reset in the middle of a copy
        do_reset();
        ready_mode = 0;
        #10;
        do_commit("hello");
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_byte", out_byte, 8'h00);
        chk("mid_ready", commit_ready, 1'b1);
        chk("mid_len", drained_len, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 1;
        do_commit("ok");
        wait_idle("ok");

        // Random cumulative traffic with random backpressure
        do_reset();
        ready_mode = 2;
        s = "";
        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                s = {s, rand_chars($urandom_range(1, 20))};
                do_commit(s);
            end else if (r < 8) begin
                do_commit(s);
            end else if (r == 8) begin
                if (s.len() > 0) begin
                    int n;
                    n = $urandom_range(0, s.len() - 1);
                    s = (n == 0) ? "" : s.substr(0, n - 1);
                end
                do_commit(s);
            end else begin
                wait_idle("rnd_mid");
            end
        end
        wait_idle("rnd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
